// File: rtl/calc2_port_responder_if.sv
// Request/response bus of the two-operand calculator port responder.
// Requests span two cycles: command + operand 1, then operand 2.
interface calc2_port_responder_if;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  out_resp, out_data, out_tag
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output out_resp, out_data, out_tag
    );
endinterface

// File: rtl/calc2_port_responder.sv
// Two-cycle request capture, 4-deep request FIFO and a single executor for
// add/sub and bit-serial shifts, returning one-cycle responses in order.
module calc2_port_responder (
    input  logic                          c_clk,
    input  logic [6:0]                    reset,
    calc2_port_responder_if.slave         bus
);
    localparam int unsigned Depth = 4;

    localparam logic [3:0] CmdAdd = 4'd1;
    localparam logic [3:0] CmdSub = 4'd2;
    localparam logic [3:0] CmdShl = 4'd5;
    localparam logic [3:0] CmdShr = 4'd6;

    typedef enum logic {StIdle, StOpnd2} cap_state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
    } req_t;

    logic in_rst;
    assign in_rst = |reset;

    // Capture FSM
    cap_state_e  cap_state_q;
    logic [3:0]  cap_cmd_q;
    logic [1:0]  cap_tag_q;
    logic [31:0] cap_op1_q;

    always_ff @(posedge c_clk) begin
        if (in_rst) begin
            cap_state_q <= StIdle;
            cap_cmd_q   <= '0;
            cap_tag_q   <= '0;
            cap_op1_q   <= '0;
        end else begin
            case (cap_state_q)
                StIdle: begin
                    if (bus.req_cmd_in != 4'd0) begin
                        cap_cmd_q   <= bus.req_cmd_in;
                        cap_tag_q   <= bus.req_tag_in;
                        cap_op1_q   <= bus.req_data_in;
                        cap_state_q <= StOpnd2;
                    end
                end
                StOpnd2: cap_state_q <= StIdle;
                default: cap_state_q <= StIdle;
            endcase
        end
    end

    // Request FIFO
    req_t       mem_q [Depth];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       push, push_ok, pop, ex_busy_q;
    req_t       push_req, head;

    assign push     = (cap_state_q == StOpnd2);
    assign push_req = '{cmd: cap_cmd_q, tag: cap_tag_q, op1: cap_op1_q, op2: bus.req_data_in};
    assign pop      = !ex_busy_q && (count_q != 3'd0);
    // A full FIFO still accepts a push when the executor drains the head in the same edge.
    assign push_ok  = push && ((count_q != 3'(Depth)) || pop);
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge c_clk) begin
        if (!in_rst && push_ok) begin
            mem_q[wr_ptr_q] <= push_req;
        end
    end

    always_ff @(posedge c_clk) begin
        if (in_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push_ok} - {2'b00, pop};
        end
    end

    // Executor
    logic [3:0]  ex_cmd_q;
    logic [1:0]  ex_tag_q;
    logic [31:0] ex_a_q, ex_b_q;
    logic [4:0]  ex_cnt_q;
    logic [1:0]  out_resp_q;
    logic [31:0] out_data_q;
    logic [1:0]  out_tag_q;
    logic        ex_shift;
    logic [32:0] sum;
    logic [1:0]  res_resp;
    logic [31:0] res_data;

    assign ex_shift = (ex_cmd_q == CmdShl) || (ex_cmd_q == CmdShr);
    assign sum      = {1'b0, ex_a_q} + {1'b0, ex_b_q};

    always_comb begin
        res_resp = 2'b10;
        res_data = '0;
        case (ex_cmd_q)
            CmdAdd: begin
                if (!sum[32]) begin
                    res_resp = 2'b01;
                    res_data = sum[31:0];
                end
            end
            CmdSub: begin
                if (ex_b_q <= ex_a_q) begin
                    res_resp = 2'b01;
                    res_data = ex_a_q - ex_b_q;
                end
            end
            CmdShl, CmdShr: begin
                res_resp = 2'b01;
                res_data = ex_a_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (in_rst) begin
            ex_busy_q  <= 1'b0;
            ex_cmd_q   <= '0;
            ex_tag_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_cnt_q   <= '0;
            out_resp_q <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            out_resp_q <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            if (pop) begin
                ex_busy_q <= 1'b1;
                ex_cmd_q  <= head.cmd;
                ex_tag_q  <= head.tag;
                ex_a_q    <= head.op1;
                ex_b_q    <= head.op2;
                ex_cnt_q  <= head.op2[4:0];
            end else if (ex_busy_q) begin
                if (ex_shift && (ex_cnt_q != 5'd0)) begin
                    ex_a_q   <= (ex_cmd_q == CmdShl) ? (ex_a_q << 1) : (ex_a_q >> 1);
                    ex_cnt_q <= ex_cnt_q - 5'd1;
                end else begin
                    out_resp_q <= res_resp;
                    out_data_q <= res_data;
                    out_tag_q  <= ex_tag_q;
                    ex_busy_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.out_resp = out_resp_q;
    assign bus.out_data = out_data_q;
    assign bus.out_tag  = out_tag_q;
endmodule

// File: doc/calc2_port_responder.md
CALC2_PORT_RESPONDER -- requirements
Module: calc2_port_responder

Interface
REQ-001 SHALL have port c_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 7, synchronous active-high reset; the block is in reset at any c_clk edge where any reset bit is 1.
REQ-003 SHALL have port req_cmd_in, input, 4, command (0 = no request, 1 = add, 2 = sub, 5 = shl, 6 = shr, others invalid).
REQ-004 SHALL have port req_data_in, input, 32, operand 1 in the command cycle, operand 2 in the following cycle.
REQ-005 SHALL have port req_tag_in, input, 2, request tag, sampled in the command cycle.
REQ-006 SHALL have port out_resp, output, 2, response code (00 none, 01 success, 10 overflow/underflow/invalid).
REQ-007 SHALL have port out_data, output, 32, result; 0 when out_resp is not 01.
REQ-008 SHALL have port out_tag, output, 2, tag echoed from the request; 0 when out_resp = 00.

Function
REQ-009 SHALL implement a capture FSM with states IDLE and OPND2.
REQ-010 In IDLE, req_cmd_in != 0 at edge N SHALL latch cmd, tag and operand 1, then go to OPND2.
REQ-011 In OPND2 at edge N+1, SHALL latch req_data_in as operand 2, push {cmd,tag,op1,op2} to the request FIFO, return to IDLE; req_cmd_in is ignored in that cycle.
REQ-012 Request FIFO SHALL be 4 entries deep, in order; executor holds one more entry separately (max 5 outstanding).
REQ-013 A push at a count-4 edge with no simultaneous pop SHALL drop the request silently (no response ever); push with simultaneous pop at count 4 SHALL be accepted.
REQ-014 Executor SHALL pop the FIFO head at the first edge where it is idle and the FIFO is non-empty; a request pushed at edge N+1 to an empty FIFO with idle executor is popped at edge N+2.
REQ-015 Add: 33-bit sum; carry-out -> resp 10, data 0; else resp 01, data = op1+op2 mod 2^32.
REQ-016 Sub: op2 > op1 (unsigned) -> resp 10, data 0; else resp 01, data = op1-op2.
REQ-017 Shl/shr: iterative, one bit per cycle, k = op2[4:0] shift cycles, zero fill, op2[31:5] ignored; always resp 01.
REQ-018 Invalid nonzero cmd: resp 10, data 0, tag echoed.
REQ-019 Latency: out_* SHALL be driven at pop edge + 1 + (k for shifts, 0 otherwise); for an unloaded block, edge N+3 (+k).
REQ-020 out_* SHALL be valid for exactly one cycle, then return to 0; at most one response per cycle; responses strictly in request order.
REQ-021 Executor SHALL become idle at the edge it drives a response, so back-to-back adds produce responses every 2 cycles.

Reset
REQ-022 In reset, the FSM SHALL go to IDLE, the FIFO SHALL empty, the executor SHALL idle, and out_resp/out_data/out_tag SHALL be 0 from the next cycle.
REQ-023 Reset mid-operation SHALL discard all captured, queued and executing requests with no response.
REQ-024 Inputs SHALL be ignored during reset; a command at the first edge with reset = 0 SHALL be accepted.

Verification
REQ-025 add op1=0x30, op2=0x20, tag 1, cmd at edge N -> at edge N+3: resp 01, data 0x50, tag 1; all zero at N+4.
REQ-026 add 0xFFFFFFFF + 0x1 -> resp 10, data 0; sub 0x10 - 0x20 -> resp 10, data 0; cmd 3 -> resp 10, data 0.
REQ-027 shl 0x1 by 4 -> resp 01, data 0x10 at N+7; shr 0x80000000 by 31 -> resp 01, data 0x1 at N+34.
REQ-028 shl by 31 (tag 0), then 5 adds of 1+1 (tags 1,2,3,0,1) back-to-back -> shift result first; adds tags 1,2,3,0 follow in order, 2 cycles apart, data 0x2; the fifth add (tag 1) is dropped with no response.
REQ-029 Reset asserted 5 cycles into a shl by 20 -> no response ever; outputs 0; add 2+3 right after deassert -> resp 01, data 0x5 at 3 edges after its command.
